// File: rtl/pkt_seq_gen.sv
// Sequence-numbered Ethernet test-frame generator with a valid/ready byte stream toward the MAC.
// Optional macro SEQ_ERR_INJ_EN adds an inj_skip-driven sequence-gap injector.
module pkt_seq_gen #(
    parameter int unsigned FRAME_LEN = 64,
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
    parameter logic [15:0] ETH_TYPE  = 16'h88B5,
    parameter int unsigned IFG_CYC   = 12
) (
    input  logic        sysclk,
    input  logic        nrst,
    input  logic        tx_tri,
    input  logic        sec_l,
    input  logic        inj_skip,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready,
    output logic [15:0] pcnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] fps,
    output logic        busy
);
    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam int unsigned GAP_W = (IFG_CYC > 1) ? $clog2(IFG_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    // The last idle cycle is spent in IDLE, where a pending trigger registers the next sop.
    localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYC > 1) ? GAP_W'(IFG_CYC - 1) : GAP_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t           r_state, w_next_state;
    logic             r_tri_cur, r_tri_prev, r_sec_cur, r_sec_prev;
    logic             w_tri_edge, w_sec_edge;
    logic             w_start, w_xfer, w_eop_xfer;
    logic             r_pend;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [15:0]      r_seq, r_pcnt, r_drop, r_fps, r_frm, w_frm_inc, w_pcnt_step;
    logic [GAP_W-1:0] r_gap;
    logic [7:0]       r_data;
    logic             r_valid, r_sop, r_eop, r_busy;

    function automatic logic [7:0] f_byte(input logic [IDX_W-1:0] idx, input logic [15:0] seq);
        logic [7:0] b;
        b = seq[7:0] + 8'(idx) - 8'd16;
        if (idx < IDX_W'(16)) begin
            case (idx[3:0])
                4'd0:    b = DST_MAC[47:40];
                4'd1:    b = DST_MAC[39:32];
                4'd2:    b = DST_MAC[31:24];
                4'd3:    b = DST_MAC[23:16];
                4'd4:    b = DST_MAC[15:8];
                4'd5:    b = DST_MAC[7:0];
                4'd6:    b = SRC_MAC[47:40];
                4'd7:    b = SRC_MAC[39:32];
                4'd8:    b = SRC_MAC[31:24];
                4'd9:    b = SRC_MAC[23:16];
                4'd10:   b = SRC_MAC[15:8];
                4'd11:   b = SRC_MAC[7:0];
                4'd12:   b = ETH_TYPE[15:8];
                4'd13:   b = ETH_TYPE[7:0];
                4'd14:   b = seq[15:8];
                default: b = seq[7:0];
            endcase
        end
        return b;
    endfunction

    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            r_tri_cur  <= 1'b0;
            r_tri_prev <= 1'b0;
            r_sec_cur  <= 1'b0;
            r_sec_prev <= 1'b0;
        end else begin
            r_tri_cur  <= tx_tri;
            r_tri_prev <= r_tri_cur;
            r_sec_cur  <= sec_l;
            r_sec_prev <= r_sec_cur;
        end
    end

    assign w_tri_edge = r_tri_cur & ~r_tri_prev;
    assign w_sec_edge = r_sec_cur & ~r_sec_prev;
    assign w_idx_nxt  = r_idx + IDX_W'(1);
    assign w_frm_inc  = (r_frm == 16'hFFFF) ? r_frm : r_frm + 16'd1;

`ifdef SEQ_ERR_INJ_EN
    logic r_inj_cur, r_inj_prev, r_inj_pend;

    // Skip requests merge until the next eop, which consumes them as a +2 step.
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            r_inj_cur  <= 1'b0;
            r_inj_prev <= 1'b0;
            r_inj_pend <= 1'b0;
        end else begin
            r_inj_cur  <= inj_skip;
            r_inj_prev <= r_inj_cur;
            if (r_inj_cur & ~r_inj_prev) begin
                r_inj_pend <= 1'b1;
            end else if (w_eop_xfer) begin
                r_inj_pend <= 1'b0;
            end
        end
    end

    assign w_pcnt_step = r_inj_pend ? 16'd2 : 16'd1;
`else
    logic w_unused_inj;
    assign w_unused_inj = inj_skip;
    assign w_pcnt_step  = 16'd1;
`endif

    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_xfer       = 1'b0;
        w_eop_xfer   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tri_edge || r_pend) begin
                    w_start      = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                w_xfer = r_valid & tx_ready;
                if (r_valid && tx_ready && r_eop) begin
                    w_eop_xfer   = 1'b1;
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap <= GAP_W'(1)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Frame byte pipeline: next byte is registered on start or on each transfer.
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            r_idx   <= '0;
            r_seq   <= 16'd0;
            r_gap   <= '0;
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            if (w_start) begin
                r_seq   <= r_pcnt;
                r_idx   <= '0;
                r_data  <= f_byte('0, r_pcnt);
                r_valid <= 1'b1;
                r_sop   <= 1'b1;
                r_eop   <= 1'b0;
            end else if (w_xfer) begin
                r_sop <= 1'b0;
                if (r_eop) begin
                    r_valid <= 1'b0;
                    r_eop   <= 1'b0;
                    r_data  <= 8'd0;
                    r_gap   <= GAP_LOAD;
                end else begin
                    r_idx  <= w_idx_nxt;
                    r_data <= f_byte(w_idx_nxt, r_seq);
                    r_eop  <= (w_idx_nxt == LAST_IDX);
                end
            end else if (r_state == S_GAP) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    // Trigger buffering, sequence number and per-second rate counters.
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            r_pend <= 1'b0;
            r_drop <= 16'd0;
            r_pcnt <= 16'd0;
            r_frm  <= 16'd0;
            r_fps  <= 16'd0;
        end else begin
            if (w_tri_edge && (r_state != S_IDLE)) begin
                if (r_pend) begin
                    r_drop <= (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;
                end else begin
                    r_pend <= 1'b1;
                end
            end else if (w_start && !w_tri_edge) begin
                r_pend <= 1'b0;
            end
            if (w_eop_xfer) begin
                r_pcnt <= r_pcnt + w_pcnt_step;
            end
            if (w_sec_edge) begin
                r_fps <= w_eop_xfer ? w_frm_inc : r_frm;
                r_frm <= 16'd0;
            end else if (w_eop_xfer) begin
                r_frm <= w_frm_inc;
            end
        end
    end

    assign tx_data  = r_data;
    assign tx_valid = r_valid;
    assign tx_sop   = r_sop;
    assign tx_eop   = r_eop;
    assign pcnt     = r_pcnt;
    assign drop_cnt = r_drop;
    assign fps      = r_fps;
    assign busy     = r_busy;

endmodule

// File: doc/pkt_seq_gen.md
Name: pkt_seq_gen

Overview:
Transmit-side sequence-numbered test-frame generator for the tge/tfe sender path. Each rising edge of tx_tri produces one Ethernet test frame carrying a 16-bit sequence number. Frames go out as a byte stream with a valid/ready handshake toward the MAC. The far-end checker counts gaps and repeats in the sequence. The block also reports dropped triggers and a per-second frame rate.

Parameters:
FRAME_LEN, 64, total frame bytes excluding FCS; legal range 60..1514
DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, bytes 0-5
SRC_MAC, 48'h0200_0000_0001, source MAC, bytes 6-11
ETH_TYPE, 16'h88B5, EtherType, bytes 12-13
IFG_CYC, 12, idle cycles forced after each eop

Ports:
sysclk  in  1  system clock
nrst  in  1  asynchronous active-low reset
tx_tri  in  1  send request, level; rising edge is detected internally
sec_l  in  1  one-second tick, level; rising edge is detected internally
inj_skip  in  1  error-injection request, level; used only with SEQ_ERR_INJ_EN
tx_data  out  8  frame byte
tx_valid  out  1  tx_data valid
tx_sop  out  1  first byte of the frame
tx_eop  out  1  last byte of the frame
tx_ready  in  1  MAC accepts the byte
pcnt  out  16  sequence number of the next frame to send
drop_cnt  out  16  count of dropped triggers, saturating
fps  out  16  frames completed in the previous second
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, sysclk; asynchronous active-low reset, nrst. All outputs are 0 during reset, all internal state cleared, state = IDLE.
- Edge detection: tx_tri, sec_l and inj_skip each pass through a 2-flop register pair. A rising edge is prev=0 & cur=1, giving 2 cycles of detection latency. The synchronizer flops are cleared by reset.
- Handshake: a byte transfers when tx_valid & tx_ready. While tx_valid=1 and tx_ready=0, tx_data, tx_sop and tx_eop are held stable. tx_valid never drops mid-frame.
- State machine:
  - IDLE: on a trigger edge or with pend=1, go to SEND. Latch seq_l = pcnt. Clear pend if it was the source. Byte index = 0.
  - SEND: tx_valid=1 and the frame is driven byte by byte.
    - Bytes 0-5 DST_MAC and 6-11 SRC_MAC, MSB first.
    - Bytes 12-13 ETH_TYPE.
    - Bytes 14-15 seq_l, big-endian.
    - Byte i for i>=16 is (seq_l[7:0] + i - 16) mod 256.
    - The byte index advances only on transfer.
    - On transfer of byte FRAME_LEN-1 (eop): pcnt <= pcnt+1, increment the frame counter, load the gap counter with IFG_CYC, go to GAP.
  - GAP: tx_valid=0. Decrement the gap counter each cycle; at 0, go to IDLE.
  - Back-to-back: with IFG_CYC=12 and pend set, sop of the next frame is the 13th cycle after the eop transfer cycle.
- Trigger buffering: the pending flag pend is one deep.
  - A trigger edge while busy=1 sets pend.
  - A trigger edge while pend is already 1 increments drop_cnt, which saturates at 16'hFFFF.
  - A trigger edge on the same cycle the FSM leaves IDLE counts as the current frame, not as pending.
- pcnt: 16-bit, wraps FFFF->0000 with no flag. The seq field is seq_l latched at sop, so a pcnt change mid-frame cannot alter it.
- fps: a 16-bit frame counter increments on each eop transfer.
  - On a sec_l edge: fps <= counter, then counter <= 0.
  - If eop and the sec_l edge coincide, that frame counts in the new value loaded into fps, and the counter restarts at 0.
  - The counter saturates at 16'hFFFF.
- Reset mid-frame: the frame is abandoned immediately with tx_valid=0 and no eop. pcnt returns to 0.

Optional Feature:
Macro SEQ_ERR_INJ_EN.
- Defined: an inj_skip edge sets inj_pend. At the next eop transfer, pcnt <= pcnt+2 and inj_pend is cleared, so the far-end checker sees a gap of 2.
  - Multiple edges before that eop merge into one skip.
- Undefined: inj_skip is ignored and no logic is generated for it.

Test Plan:
- Reset, one tx_tri pulse, tx_ready=1 -> 64 bytes. Bytes 14-15 = 00 00, byte 16 = 00, byte 63 = 2F. sop on byte 0, eop on byte 63. pcnt then 1.
- Three pulses 5 cycles apart during frame 0 -> frames with seq 0 and 1 sent back-to-back with an IFG of 12 idle cycles. drop_cnt = 1, pcnt = 2.
- tx_ready toggled 0/1 pseudo-randomly during a frame with pcnt=16'hFFFF -> data/sop/eop stable while stalled. seq field = FF FF, byte 16 = FF, byte 17 = 00. pcnt afterwards = 0000.
- 10 frames, then a sec_l edge, then 3 frames, then a sec_l edge -> fps = 10 after the first tick and 3 after the second. An eop coincident with a tick is counted into the new fps value.
- SEQ_ERR_INJ_EN defined: frames seq 0, 1, then an inj_skip edge during frame 1 -> next frame carries seq 3. Without the macro -> seq 2.
- nrst asserted at byte 20 of a frame -> tx_valid=0 immediately, all outputs 0. The next trigger sends seq 0 with a full frame.
